// File: rtl/priority_pkg.sv
// priority_pkg: shared state enum and extreme-bit helpers for the priority encoder/serializer family
package priority_pkg;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
  localparam int MAX_W = 64;
  function automatic logic [MAX_W-1:0] lowest_onehot(input logic [MAX_W-1:0] v);
    return v & (-v);
  endfunction
  function automatic logic [MAX_W-1:0] highest_onehot(input logic [MAX_W-1:0] v);
    logic [MAX_W-1:0] r;
    r = {<<{v}};
    r = r & (-r);
    return {<<{r}};
  endfunction
endpackage

// File: rtl/onehot_to_index.sv
// onehot_to_index: binary position of the single set bit (0 for an all-zero vector)
//   onehot_i [WIDTH] -> index_o [IDX_W], purely combinational OR-reduction
module onehot_to_index #(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] onehot_i,
  output logic [IDX_W-1:0] index_o
);
  always_comb begin
    index_o = '0;
    for (int i = 0; i < WIDTH; i++) index_o = index_o | (onehot_i[i] ? IDX_W'(i) : '0);
  end
endmodule

// File: rtl/priority_bit_serializer.sv
// priority_bit_serializer: emits every set bit of a captured word as a one-hot beat in priority order
//   clk_i, srst_i (sync, active-high); data_i/data_val_i/data_rdy_o word input handshake;
//   onehot_o, index_o, zero_o, last_o, val_o/rdy_i beat output handshake
module priority_bit_serializer
  import priority_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1,
  parameter int IDX_W     = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             data_val_i,
  output logic             data_rdy_o,
  output logic [WIDTH-1:0] onehot_o,
  output logic [IDX_W-1:0] index_o,
  output logic             zero_o,
  output logic             last_o,
  output logic             val_o,
  input  logic             rdy_i
);
  state_t st, st_nx;
  logic [WIDTH-1:0] res, res_nx, scan_in, scan_sel;
  logic busy;
  // residue is held in scan order (bit 0 = next to emit); MSB-first mirrors in and out
  for (genvar i = 0; i < WIDTH; i++) begin : g_rev
    assign scan_in[i]  = LSB_FIRST ? data_i[i]   : data_i[WIDTH-1-i];
    assign onehot_o[i] = LSB_FIRST ? scan_sel[i] : scan_sel[WIDTH-1-i];
  end
  assign busy       = st == BUSY;
  assign val_o      = busy;
  assign scan_sel   = busy ? WIDTH'(lowest_onehot(MAX_W'(res))) : '0;
  assign last_o     = busy & ~|(res & (res - WIDTH'(1)));
  assign zero_o     = busy & ~|res;
  assign data_rdy_o = ~busy | (last_o & rdy_i);
  always_comb begin
    st_nx  = st;
    res_nx = res;
    if (data_rdy_o && data_val_i) begin
      st_nx  = BUSY;
      res_nx = scan_in;
    end else if (busy && rdy_i) begin
      res_nx = res & ~scan_sel;
      st_nx  = last_o ? IDLE : BUSY;
    end
  end
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      st  <= IDLE;
      res <= '0;
    end else begin
      st  <= st_nx;
      res <= res_nx;
    end
  end
  onehot_to_index #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_idx (
    .onehot_i(onehot_o),
    .index_o (index_o)
  );
endmodule

// File: tb/tb_priority_bit_serializer.sv
// tb_priority_bit_serializer: scoreboard bench driving an LSB-first and an MSB-first instance in lockstep
module tb_priority_bit_serializer;
  typedef struct {
    logic [7:0] oh;
    logic [2:0] idx;
    logic       zero;
    logic       last;
  } beat_t;
  logic clk = 1'b0, srst = 1'b1, dval = 1'b0, rdy = 1'b1, t = 1'b0;
  logic [7:0] din = '0;
  logic [7:0] oh[2];
  logic [2:0] idx[2];
  logic drdy[2], zr[2], lst[2], val[2];
  beat_t q[2][$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  priority_bit_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
    .clk_i(clk), .srst_i(srst), .data_i(din), .data_val_i(dval), .data_rdy_o(drdy[0]),
    .onehot_o(oh[0]), .index_o(idx[0]), .zero_o(zr[0]), .last_o(lst[0]), .val_o(val[0]), .rdy_i(rdy)
  );
  priority_bit_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
    .clk_i(clk), .srst_i(srst), .data_i(din), .data_val_i(dval), .data_rdy_o(drdy[1]),
    .onehot_o(oh[1]), .index_o(idx[1]), .zero_o(zr[1]), .last_o(lst[1]), .val_o(val[1]), .rdy_i(rdy)
  );
  function automatic void chk(string n, int d, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s[dut%0d]: got %0h expected %0h", n, d, a, e);
    end
  endfunction
  // reference: set-bit positions listed in priority order; an empty word is a single zero beat
  function automatic void push_word(int d, logic [7:0] w);
    int pos[$];
    beat_t b;
    for (int i = 0; i < 8; i++) if (w[i]) pos.push_back(i);
    if (d == 0) pos.reverse();
    if (pos.size() == 0) begin
      b.oh = '0; b.idx = '0; b.zero = 1'b1; b.last = 1'b1;
      q[d].push_back(b);
    end else foreach (pos[k]) begin
      b.oh = 8'(1) << pos[k]; b.idx = 3'(pos[k]); b.zero = 1'b0; b.last = (k == pos.size() - 1);
      q[d].push_back(b);
    end
  endfunction
  always begin
    @(negedge clk);
    #2;
    if (srst) begin
      q[0].delete();
      q[1].delete();
    end else for (int d = 0; d < 2; d++) begin
      logic busy, er;
      beat_t h;
      busy = q[d].size() != 0;
      er = !busy || (q[d].size() == 1 && rdy);
      chk("val_o", d, val[d], busy);
      chk("data_rdy_o", d, drdy[d], er);
      if (busy) begin
        h = q[d][0];
        chk("onehot_o", d, oh[d], h.oh);
        chk("index_o", d, idx[d], h.idx);
        chk("zero_o", d, zr[d], h.zero);
        chk("last_o", d, lst[d], h.last);
        if (rdy) void'(q[d].pop_front());
      end else begin
        chk("idle_onehot", d, oh[d], 0);
        chk("idle_index", d, idx[d], 0);
        chk("idle_zero", d, zr[d], 0);
        chk("idle_last", d, lst[d], 0);
      end
      if (dval && er) push_word(d, din);
    end
  end
  task automatic step(input logic v, input logic [7:0] d, input logic r, input logic s, output logic acc);
    @(negedge clk);
    #1;
    dval = v; din = d; rdy = r; srst = s;
    #1;
    acc = v & drdy[1] & ~s;
  endtask
  task automatic send(input logic [7:0] w, input bit tog);
    logic a;
    int n = 0;
    do begin
      step(1'b1, w, tog ? t : 1'b1, 1'b0, a);
      t = ~t;
      n++;
    end while (!a && n < 64);
    if (!a) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: word %0h not taken within 64 cycles", w);
    end
  endtask
  initial begin
    logic a;
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b1, a);
    send(8'hA4, 0);
    send(8'h00, 0);
    send(8'hFF, 1);
    send(8'h01, 0);
    send(8'h80, 0);
    send(8'hF0, 0);
    step(1'b0, 8'h00, 1'b1, 1'b0, a);
    step(1'b0, 8'h00, 1'b1, 1'b0, a);
    step(1'b0, 8'h00, 1'b1, 1'b1, a);
    send(8'h02, 0);
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0, a);
    for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b1, 1'b0, a);
    @(negedge clk);
    #3;
    for (int d = 0; d < 2; d++) chk("queue_drained", d, q[d].size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
